// File: rtl/ex_pkg.sv
// Shared types and encodings for the EX issue controller: FSM states, decode
// constants, condition codes, CPSR bit positions and instruction-class decode.
package ex_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2,
    HALT   = 2'd3
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;

  localparam logic [2:0] BR_ALWAYS = 3'b000;
  localparam logic [2:0] BR_COND   = 3'b001;
  localparam logic [2:0] SYS_HALT  = 3'b111;

  localparam logic [1:0] FL_MOVE   = 2'b00;
  localparam logic [1:0] FL_BRANCH = 2'b01;
  localparam logic [1:0] FL_SYS    = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_MOVE  = 3'd2,
    CLS_BR_AL = 3'd3,
    CLS_BR_CC = 3'd4,
    CLS_HALT  = 3'd5
  } cls_e;

  // Everything not explicitly recognised collapses to NOP.
  function automatic cls_e decode_class(input logic       special,
                                        input logic [1:0] first_ld,
                                        input logic [2:0] alu_oc);
    cls_e cls;
    cls = CLS_NOP;
    if (special) begin
      cls = CLS_ALU;
    end else begin
      case (first_ld)
        FL_MOVE:   cls = CLS_MOVE;
        FL_BRANCH: begin
          if (alu_oc == BR_ALWAYS)    cls = CLS_BR_AL;
          else if (alu_oc == BR_COND) cls = CLS_BR_CC;
        end
        FL_SYS:    if (alu_oc == SYS_HALT) cls = CLS_HALT;
        default:   cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ex_cond_eval.sv
// Combinational condition-code evaluator over CPSR {N,C,Z,V}; kept standalone so
// fetch-side prediction can reuse it.
module ex_cond_eval
  import ex_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_take
);

  logic w_n, w_c, w_z, w_v, w_gt;

  assign w_n  = i_flags[FLAG_N];
  assign w_c  = i_flags[FLAG_C];
  assign w_z  = i_flags[FLAG_Z];
  assign w_v  = i_flags[FLAG_V];
  assign w_gt = !w_z && (w_n == w_v);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_take = 1'b0;
    case (cond_e'(i_cond))
      C_EQ: o_take = w_z;
      C_NE: o_take = !w_z;
      C_CS: o_take = w_c;
      C_CC: o_take = !w_c;
      C_MI: o_take = w_n;
      C_PL: o_take = !w_n;
      C_VS: o_take = w_v;
      C_VC: o_take = !w_v;
      C_HI: o_take = w_c && !w_z;
      C_LS: o_take = !(w_c && !w_z);
      C_GE: o_take = (w_n == w_v);
      C_LT: o_take = (w_n != w_v);
      C_GT: o_take = w_gt;
      C_LE: o_take = !w_gt;
      C_AL: o_take = 1'b1;
      C_NV: o_take = 1'b0;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// EX issue controller: accepts one decoded instruction, pulses the datapath for a
// compute cycle, then commits writeback, CPSR update or branch redirect.
module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OFF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [1:0]        id_first_ld,
  input  logic              id_special,
  input  logic [3:0]        id_second_ld,
  input  logic [2:0]        id_alu_oc,
  input  logic [3:0]        id_b_cond,
  input  logic [2:0]        id_dest_reg,
  input  logic [OFF_W-1:0]  id_offset,
  input  logic [PC_W-1:0]   id_pc,
  output logic              ex_issue,
  input  logic [DATA_W:0]   ex_result,
  input  logic [DATA_W-1:0] ex_op1,
  input  logic [DATA_W-1:0] ex_op2,
  output logic              wb_en,
  output logic              wb_sel,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic              halted
);

  state_e              r_state, w_state_nxt;
  cls_e                r_cls;
  logic [2:0]          r_alu_oc;
  logic                r_set_flags;
  logic [3:0]          r_b_cond;
  logic [2:0]          r_dest;
  logic [OFF_W-1:0]    r_offset;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W:0]     r_result;
  logic                r_a31, r_b31;
  logic [3:0]          r_flags, w_flags_nxt;
  logic                r_wb_sel;
  logic [2:0]          r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;
  logic [PC_W-1:0]     r_br_target;
  logic                w_cond_take, w_br_go, w_is_wr;
  logic [PC_W-1:0]     w_br_addr;
  logic                w_unused;

  // Only the sign bits of the operands and the set-flags bit of second_ld matter here.
  assign w_unused = ^{id_second_ld[2:0], ex_op1[DATA_W-2:0], ex_op2[DATA_W-2:0]};

  ex_cond_eval u_cond_eval (
    .i_flags (r_flags),
    .i_cond  (r_b_cond),
    .o_take  (w_cond_take)
  );

  assign w_is_wr   = (r_cls == CLS_ALU) || (r_cls == CLS_MOVE);
  assign w_br_go   = (r_cls == CLS_BR_AL) || ((r_cls == CLS_BR_CC) && w_cond_take);
  assign w_br_addr = r_pc + {{(PC_W-OFF_W){r_offset[OFF_W-1]}}, r_offset};

  always_comb begin
    w_state_nxt = r_state;
    id_ready    = 1'b0;
    ex_issue    = 1'b0;
    wb_en       = 1'b0;
    br_taken    = 1'b0;
    halted      = 1'b0;
    case (r_state)
      IDLE: begin
        id_ready = 1'b1;
        if (id_valid) w_state_nxt = EXEC;
      end
      EXEC: begin
        ex_issue    = 1'b1;
        w_state_nxt = COMMIT;
      end
      COMMIT: begin
        wb_en       = w_is_wr;
        br_taken    = w_br_go;
        w_state_nxt = (r_cls == CLS_HALT) ? HALT : IDLE;
      end
      HALT:    halted = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  // C and V only move for ADD/SUB; logical ops refresh N and Z alone.
  always_comb begin
    w_flags_nxt = r_flags;
    if (r_cls == CLS_ALU && r_set_flags) begin
      w_flags_nxt[FLAG_N] = r_result[DATA_W-1];
      w_flags_nxt[FLAG_Z] = (r_result[DATA_W-1:0] == '0);
      if (r_alu_oc == ALU_ADD) begin
        w_flags_nxt[FLAG_C] = r_result[DATA_W];
        w_flags_nxt[FLAG_V] = (r_a31 == r_b31) && (r_result[DATA_W-1] != r_a31);
      end else if (r_alu_oc == ALU_SUB) begin
        w_flags_nxt[FLAG_C] = r_result[DATA_W];
        w_flags_nxt[FLAG_V] = (r_a31 != r_b31) && (r_result[DATA_W-1] != r_a31);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls       <= CLS_NOP;
      r_alu_oc    <= '0;
      r_set_flags <= 1'b0;
      r_b_cond    <= '0;
      r_dest      <= '0;
      r_offset    <= '0;
      r_pc        <= '0;
      r_result    <= '0;
      r_a31       <= 1'b0;
      r_b31       <= 1'b0;
      r_flags     <= '0;
      r_wb_sel    <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_br_target <= '0;
    end else begin
      if (r_state == IDLE && id_valid) begin
        r_cls       <= decode_class(id_special, id_first_ld, id_alu_oc);
        r_alu_oc    <= id_alu_oc;
        r_set_flags <= id_second_ld[3];
        r_b_cond    <= id_b_cond;
        r_dest      <= id_dest_reg;
        r_offset    <= id_offset;
        r_pc        <= id_pc;
      end
      // Commit-visible registers load at the end of EXEC so they are valid throughout COMMIT.
      if (r_state == EXEC) begin
        r_result <= ex_result;
        r_a31    <= ex_op1[DATA_W-1];
        r_b31    <= ex_op2[DATA_W-1];
        if (w_is_wr) begin
          r_wb_sel  <= (r_cls == CLS_MOVE);
          r_wb_addr <= r_dest;
          r_wb_data <= ex_result[DATA_W-1:0];
        end
        if (w_br_go) r_br_target <= w_br_addr;
      end
      if (r_state == COMMIT) r_flags <= w_flags_nxt;
    end
  end

  assign wb_sel    = r_wb_sel;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign flags     = r_flags;
  assign br_target = r_br_target;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: expected commits are queued at issue and
// popped by a monitor whenever the controller pulses wb_en or br_taken.
module tb_ex_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready, id_special;
  logic [1:0]  id_first_ld;
  logic [3:0]  id_second_ld, id_b_cond;
  logic [2:0]  id_alu_oc, id_dest_reg;
  logic [15:0] id_offset;
  logic [31:0] id_pc;
  logic        ex_issue;
  logic [32:0] ex_result;
  logic [31:0] ex_op1, ex_op2;
  logic        wb_en, wb_sel;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic        br_taken, halted;
  logic [31:0] br_target;

  always #5 clk = ~clk;

  ex_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_first_ld(id_first_ld), .id_special(id_special), .id_second_ld(id_second_ld),
    .id_alu_oc(id_alu_oc), .id_b_cond(id_b_cond), .id_dest_reg(id_dest_reg),
    .id_offset(id_offset), .id_pc(id_pc), .ex_issue(ex_issue), .ex_result(ex_result),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .wb_en(wb_en), .wb_sel(wb_sel), .wb_addr(wb_addr),
    .wb_data(wb_data), .flags(flags), .br_taken(br_taken), .br_target(br_target),
    .halted(halted)
  );

  typedef struct {
    logic        is_br;
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] tgt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  m_flags = 4'b0000;   // {N,C,Z,V}

  // Independent reading of the condition table.
  function automatic logic model_take(input logic [3:0] f, input logic [3:0] c);
    logic n, cy, z, v;
    n = f[3]; cy = f[2]; z = f[1]; v = f[0];
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cy;           4'h3: return !cy;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cy && !z;     4'h9: return !cy || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wb_en === 1'b1 || br_taken === 1'b1)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_commit: wb_en=%b br_taken=%b, required no commit", wb_en, br_taken);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.is_br) begin
          if (br_taken !== 1'b1 || wb_en !== 1'b0 || br_target !== mon_e.tgt) begin
            n_err++;
            $display("FAIL branch_commit: br_taken=%b wb_en=%b br_target=%h, required 1 0 %h",
                     br_taken, wb_en, br_target, mon_e.tgt);
          end
        end else if (wb_en !== 1'b1 || br_taken !== 1'b0 || wb_sel !== mon_e.sel ||
                     wb_addr !== mon_e.addr || wb_data !== mon_e.data) begin
          n_err++;
          $display("FAIL wb_commit: wb_en=%b br=%b sel=%b addr=%0d data=%h, required 1 0 %b %0d %h",
                   wb_en, br_taken, wb_sel, wb_addr, wb_data, mon_e.sel, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic drive_idle();
    id_valid = 0; id_special = 0; id_first_ld = 2'b10; id_second_ld = 0; id_alu_oc = 0;
    id_b_cond = 0; id_dest_reg = 0; id_offset = 0; id_pc = 0;
    ex_result = 0; ex_op1 = 0; ex_op2 = 0;
  endtask

  // Issue one instruction, queue its expected commit, and follow it through commit.
  task automatic send(input logic sp, input logic [1:0] fl, input logic [3:0] sl,
                      input logic [2:0] oc, input logic [3:0] cond, input logic [2:0] dst,
                      input logic [15:0] off, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    exp_t        e;
    logic        halt_exp;
    int          waited;
    halt_exp = 1'b0;
    case (oc)
      3'b001:  r = {1'b0, a} + {1'b0, b};
      3'b010:  r = {1'b0, a} - {1'b0, b};
      3'b011:  r = {1'b0, a & b};
      3'b100:  r = {1'b0, a | b};
      3'b101:  r = {1'b0, a ^ b};
      3'b110:  r = {1'b0, ~a};
      default: r = {1'b0, b};
    endcase
    e.is_br = 0; e.sel = 0; e.addr = dst; e.data = r[31:0];
    e.tgt = pc + {{16{off[15]}}, off};
    if (sp) begin
      q.push_back(e);
      if (sl[3]) begin
        m_flags[3] = r[31];
        m_flags[1] = (r[31:0] == 32'd0);
        if (oc == 3'b001) begin
          m_flags[2] = r[32];
          m_flags[0] = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (oc == 3'b010) begin
          m_flags[2] = r[32];
          m_flags[0] = (a[31] != b[31]) && (r[31] != a[31]);
        end
      end
    end else if (fl == 2'b00) begin
      e.sel = 1;
      q.push_back(e);
    end else if (fl == 2'b01 && (oc == 3'b000 || (oc == 3'b001 && model_take(m_flags, cond)))) begin
      e.is_br = 1;
      q.push_back(e);
    end else if (fl == 2'b11 && oc == 3'b111) begin
      halt_exp = 1'b1;
    end
    waited = 0;
    while (id_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (id_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: id_ready=%b after %0d cycles, required 1", id_ready, waited);
    end
    id_special = sp; id_first_ld = fl; id_second_ld = sl; id_alu_oc = oc; id_b_cond = cond;
    id_dest_reg = dst; id_offset = off; id_pc = pc;
    ex_result = r; ex_op1 = a; ex_op2 = b;
    id_valid = 1;
    @(posedge clk); #1;
    id_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ex_issue !== 1'b1 || id_ready !== 1'b0) begin
      n_err++;
      $display("FAIL exec_cycle: ex_issue=%b id_ready=%b, required 1 0", ex_issue, id_ready);
    end
    @(negedge clk);
    @(posedge clk); #1;
    n_vec++;
    if (flags !== m_flags || q.size() != 0 || halted !== halt_exp) begin
      n_err++;
      $display("FAIL post_commit: flags=%b pending=%0d halted=%b, required %b 0 %b",
               flags, q.size(), halted, m_flags, halt_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    n_vec++;
    if (id_ready !== 1 || ex_issue !== 0 || wb_en !== 0 || br_taken !== 0 || halted !== 0 ||
        flags !== 4'b0000 || wb_data !== 0 || wb_addr !== 0 || br_target !== 0 || wb_sel !== 0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b iss=%b wb=%b br=%b hlt=%b fl=%b data=%h addr=%0d tgt=%h",
               id_ready, ex_issue, wb_en, br_taken, halted, flags, wb_data, wb_addr, br_target);
    end
    // ADDS overflowing to zero, interrupted by reset in its EXEC cycle.
    id_special = 1; id_second_ld = 4'b1000; id_alu_oc = 3'b001; id_dest_reg = 3'd5;
    ex_op1 = 32'hFFFF_FFFF; ex_op2 = 32'h1; ex_result = 33'h1_0000_0000;
    id_valid = 1;
    @(posedge clk); #1;
    id_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ex_issue !== 1) begin
      n_err++;
      $display("FAIL reset_exec_reached: ex_issue=%b, required 1", ex_issue);
    end
    rst_n = 0;
    #1;
    n_vec++;
    if (wb_en !== 0 || ex_issue !== 0 || flags !== 4'b0000 || id_ready !== 1) begin
      n_err++;
      $display("FAIL reset_mid_exec: wb_en=%b ex_issue=%b flags=%b id_ready=%b, required 0 0 0000 1",
               wb_en, ex_issue, flags, id_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    drive_idle();
    repeat (3) @(negedge clk);
    n_vec++;
    if (id_ready !== 1 || flags !== 4'b0000 || wb_data !== 0 || wb_addr !== 0) begin
      n_err++;
      $display("FAIL reset_release: id_ready=%b flags=%b wb_data=%h wb_addr=%0d, required 1 0000 0 0",
               id_ready, flags, wb_data, wb_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_flags();
    send(1, 2'b00, 4'b1000, 3'b001, 4'h0, 3'd1, 16'h0, 32'h0, 32'hFFFF_FFFF, 32'h1);
    n_vec++;
    if (flags !== 4'b0110) begin
      n_err++;
      $display("FAIL adds_flags: flags=%b, required 0110", flags);
    end
    send(1, 2'b00, 4'b0000, 3'b001, 4'h0, 3'd3, 16'h0, 32'h0, 32'd5, 32'd7);
    send(1, 2'b00, 4'b1000, 3'b010, 4'h0, 3'd2, 16'h0, 32'h0, 32'h8000_0000, 32'h1);
    n_vec++;
    if (flags !== 4'b0001) begin
      n_err++;
      $display("FAIL subs_flags: flags=%b, required 0001", flags);
    end
    send(1, 2'b00, 4'b1000, 3'b011, 4'h0, 3'd4, 16'h0, 32'h0, 32'h0000_000F, 32'h0000_00F0);
    n_vec++;
    if (flags !== 4'b0011) begin
      n_err++;
      $display("FAIL ands_flags: flags=%b, required 0011", flags);
    end
  endtask

  task automatic test_branch();
    send(0, 2'b01, 4'b0000, 3'b001, 4'h0, 3'd0, 16'hFFF0, 32'h0000_0100, 32'h0, 32'h0);
    send(0, 2'b01, 4'b0000, 3'b001, 4'h1, 3'd0, 16'h0040, 32'h0000_0300, 32'h0, 32'h0);
    n_vec++;
    if (br_target !== 32'h0000_00F0) begin
      n_err++;
      $display("FAIL bne_target_held: br_target=%h, required 000000f0", br_target);
    end
    send(0, 2'b01, 4'b0000, 3'b001, 4'hB, 3'd0, 16'h0010, 32'h0000_0200, 32'h0, 32'h0);
    send(0, 2'b01, 4'b0000, 3'b001, 4'hA, 3'd0, 16'h0010, 32'h0000_0400, 32'h0, 32'h0);
    send(0, 2'b01, 4'b0000, 3'b001, 4'hF, 3'd0, 16'h0010, 32'h0000_0500, 32'h0, 32'h0);
    send(0, 2'b01, 4'b0000, 3'b000, 4'hF, 3'd0, 16'h0020, 32'hFFFF_FFF0, 32'h0, 32'h0);
  endtask

  task automatic test_move_nop();
    send(0, 2'b00, 4'b0000, 3'b000, 4'h0, 3'd7, 16'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    send(0, 2'b10, 4'b1000, 3'b001, 4'h0, 3'd6, 16'h0, 32'h0, 32'h1, 32'h1);
    send(0, 2'b11, 4'b0000, 3'b000, 4'h0, 3'd6, 16'h0, 32'h0, 32'h1, 32'h1);
    send(0, 2'b01, 4'b0000, 3'b010, 4'hE, 3'd6, 16'h0040, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if (wb_data !== 32'hDEAD_BEEF || wb_addr !== 3'd7 || wb_sel !== 1'b1) begin
      n_err++;
      $display("FAIL nop_holds_wb: data=%h addr=%0d sel=%b, required deadbeef 7 1",
               wb_data, wb_addr, wb_sel);
    end
  endtask

  task automatic test_back_to_back();
    int   k;
    exp_t e;
    k = 0;
    id_special = 0; id_first_ld = 2'b00; id_second_ld = 0; id_alu_oc = 0; id_dest_reg = 3'd2;
    id_valid = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (id_ready !== ((cyc % 3) == 0)) begin
        n_err++;
        $display("FAIL b2b_ready: cycle %0d id_ready=%b, required %b", cyc, id_ready, (cyc % 3) == 0);
      end
      if (id_ready === 1'b1 && k < 4) begin
        e.is_br = 0; e.sel = 1; e.addr = 3'(k + 2); e.data = 32'h1000 + k; e.tgt = 0;
        ex_result = {1'b0, e.data};
        ex_op2 = e.data;
        q.push_back(e);
        @(posedge clk); #1;
        k++;
        if (k < 4) id_dest_reg = 3'(k + 2);
        else id_valid = 0;
      end
    end
    id_valid = 0;
    @(posedge clk); #1;
    n_vec++;
    if (k != 4 || q.size() != 0 || flags !== m_flags) begin
      n_err++;
      $display("FAIL b2b_done: accepts=%0d pending=%0d flags=%b, required 4 0 %b",
               k, q.size(), flags, m_flags);
    end
  endtask

  task automatic test_halt();
    send(0, 2'b11, 4'b0000, 3'b111, 4'h0, 3'd1, 16'h0, 32'h0, 32'h0, 32'h0);
    id_special = 1; id_alu_oc = 3'b001; id_dest_reg = 3'd1; id_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (halted !== 1 || id_ready !== 0 || ex_issue !== 0) begin
        n_err++;
        $display("FAIL halt_hold: cycle %0d halted=%b id_ready=%b ex_issue=%b, required 1 0 0",
                 i, halted, id_ready, ex_issue);
      end
    end
    id_valid = 0;
    rst_n = 0;
    #1;
    n_vec++;
    if (halted !== 0 || id_ready !== 1 || flags !== 4'b0000) begin
      n_err++;
      $display("FAIL halt_reset: halted=%b id_ready=%b flags=%b, required 0 1 0000",
               halted, id_ready, flags);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_alu_flags();
    test_branch();
    test_move_nop();
    test_back_to_back();
    test_halt();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
